// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with seed load, lock-up recovery and period measurement.
// Latency: one cycle from en/init/load to lfsr; no backpressure, state advances only on en.
module lfsr_gen #(
  parameter int               WIDTH = 10,
  parameter logic [32:0]      TAPS  = 33'h481,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
  parameter int               STEPS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] lfsr,
  output logic             lockup,
  output logic             period_done,
  output logic [WIDTH:0]   period_len,
  output logic             period_valid
);

  // Tap for term x^k reads state bit k-1; the +1 term (bit 0) drops out here.
  localparam logic [WIDTH-1:0] TAP_MASK = TAPS[WIDTH:1];
  localparam logic [WIDTH:0]   CNT_MAX  = '1;

  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH:0]   cnt_q, cnt_d;
  logic [WIDTH:0]   len_q, len_d;
  logic             valid_q, valid_d;
  logic             lockup_q, lockup_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] stepped;
  logic [WIDTH:0]   cnt_inc;

  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] s, input logic d);
    return {s[WIDTH-2:0], d ^ (^(s & TAP_MASK))};
  endfunction

  always_comb begin
    stepped = lfsr_q;
    for (int i = 0; i < STEPS; i++) begin
      stepped = shift1(stepped, din);
    end
  end

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    lfsr_d   = lfsr_q;
    start_d  = start_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    valid_d  = valid_q;
    lockup_d = 1'b0;
    done_d   = 1'b0;
    if (init) begin
      lfsr_d  = SEED;
      start_d = SEED;
      cnt_d   = '0;
    end else if (load) begin
      cnt_d = '0;
      if (seed_in != '0) begin
        lfsr_d  = seed_in;
        start_d = seed_in;
      end else begin
        lfsr_d   = SEED;
        start_d  = SEED;
        lockup_d = 1'b1;
      end
    end else if (en) begin
      // All-zero state with no entropy would stick forever; restart from SEED.
      if (lfsr_q == '0 && !din) begin
        lfsr_d   = SEED;
        start_d  = SEED;
        cnt_d    = '0;
        lockup_d = 1'b1;
      end else begin
        lfsr_d = stepped;
        if (stepped == start_q) begin
          done_d  = 1'b1;
          len_d   = cnt_inc;
          valid_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q   <= SEED;
      start_q  <= SEED;
      cnt_q    <= '0;
      len_q    <= '0;
      valid_q  <= 1'b0;
      lockup_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      lfsr_q   <= lfsr_d;
      start_q  <= start_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      valid_q  <= valid_d;
      lockup_q <= lockup_d;
      done_q   <= done_d;
    end
  end

  assign lfsr         = lfsr_q;
  assign lockup       = lockup_q;
  assign period_done  = done_q;
  assign period_len   = len_q;
  assign period_valid = valid_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: three parameterisations driven in lockstep against an arithmetic model.
module tb_lfsr_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, init, load, en, din;
  logic [9:0]  seed_in;
  logic [9:0]  lfsr_a, lfsr_b;
  logic [3:0]  lfsr_c;
  logic        lock_a, lock_b, lock_c, pd_a, pd_b, pd_c, pv_a, pv_b, pv_c;
  logic [10:0] len_a, len_b;
  logic [4:0]  len_c;

  lfsr_gen u_def (
    .clk(clk), .rst(rst), .init(init), .load(load), .seed_in(seed_in), .en(en), .din(din),
    .lfsr(lfsr_a), .lockup(lock_a), .period_done(pd_a), .period_len(len_a), .period_valid(pv_a)
  );

  lfsr_gen #(.STEPS(2)) u_s2 (
    .clk(clk), .rst(rst), .init(init), .load(load), .seed_in(seed_in), .en(en), .din(din),
    .lfsr(lfsr_b), .lockup(lock_b), .period_done(pd_b), .period_len(len_b), .period_valid(pv_b)
  );

  lfsr_gen #(.WIDTH(4), .TAPS(33'h18), .SEED(4'h9), .STEPS(3)) u_w4 (
    .clk(clk), .rst(rst), .init(init), .load(load), .seed_in(seed_in[3:0]), .en(en), .din(din),
    .lfsr(lfsr_c), .lockup(lock_c), .period_done(pd_c), .period_len(len_c), .period_valid(pv_c)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: one entry per instance above.
  int unsigned mw[3]     = '{10, 10, 4};
  int unsigned mtaps[3]  = '{32'h481, 32'h481, 32'h18};
  int unsigned mseed[3]  = '{1, 1, 9};
  int unsigned msteps[3] = '{1, 2, 3};
  int unsigned m_state[3], m_start[3], m_cnt[3], m_len[3];
  bit          m_valid[3], m_lock[3], m_pd[3];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit parity_fb(input int i, input int unsigned s);
    return ($countones(s & (mtaps[i] >> 1)) % 2) == 1;
  endfunction

  function automatic int unsigned model_advance(input int i, input int unsigned s0, input bit d);
    int unsigned s;
    int unsigned mask;
    bit fb;
    s = s0;
    mask = (32'd1 << mw[i]) - 1;
    for (int k = 0; k < int'(msteps[i]); k++) begin
      fb = d ^ parity_fb(i, s);
      s = ((s << 1) | 32'(fb)) & mask;
    end
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_state[i] = mseed[i];
      m_start[i] = mseed[i];
      m_cnt[i]   = 0;
      m_len[i]   = 0;
      m_valid[i] = 0;
      m_lock[i]  = 0;
      m_pd[i]    = 0;
    end
  endtask

  task automatic model_cycle(input bit i_init, input bit i_load, input int unsigned i_seed,
                             input bit i_en, input bit i_din);
    int unsigned mask, sv, ns, c1, cmax;
    for (int i = 0; i < 3; i++) begin
      mask = (32'd1 << mw[i]) - 1;
      cmax = (32'd1 << (mw[i] + 1)) - 1;
      sv = i_seed & mask;
      m_lock[i] = 0;
      m_pd[i] = 0;
      if (i_init) begin
        m_state[i] = mseed[i]; m_start[i] = mseed[i]; m_cnt[i] = 0;
      end else if (i_load) begin
        m_cnt[i] = 0;
        if (sv != 0) begin
          m_state[i] = sv; m_start[i] = sv;
        end else begin
          m_state[i] = mseed[i]; m_start[i] = mseed[i]; m_lock[i] = 1;
        end
      end else if (i_en) begin
        if (m_state[i] == 0 && !i_din) begin
          m_state[i] = mseed[i]; m_start[i] = mseed[i]; m_cnt[i] = 0; m_lock[i] = 1;
        end else begin
          ns = model_advance(i, m_state[i], i_din);
          c1 = (m_cnt[i] + 1 > cmax) ? cmax : m_cnt[i] + 1;
          if (ns == m_start[i]) begin
            m_pd[i] = 1; m_len[i] = c1; m_valid[i] = 1; m_cnt[i] = 0;
          end else begin
            m_cnt[i] = c1;
          end
          m_state[i] = ns;
        end
      end
    end
  endtask

  task automatic cmp_inst(input string tag, input int i, input int unsigned l, input int unsigned lk,
                          input int unsigned pd, input int unsigned ln, input int unsigned pv);
    chk({tag, "_lfsr"}, l, m_state[i]);
    chk({tag, "_lockup"}, lk, 32'(m_lock[i]));
    chk({tag, "_period_done"}, pd, 32'(m_pd[i]));
    chk({tag, "_period_len"}, ln, m_len[i]);
    chk({tag, "_period_valid"}, pv, 32'(m_valid[i]));
  endtask

  task automatic compare_all();
    cmp_inst("def", 0, lfsr_a, lock_a, pd_a, len_a, pv_a);
    cmp_inst("s2", 1, lfsr_b, lock_b, pd_b, len_b, pv_b);
    cmp_inst("w4", 2, lfsr_c, lock_c, pd_c, len_c, pv_c);
  endtask

  // Drive one cycle's inputs, clock them in, then check every instance against the model.
  task automatic cyc(input bit i_init, input bit i_load, input logic [9:0] i_seed,
                     input bit i_en, input bit i_din);
    init = i_init; load = i_load; seed_in = i_seed; en = i_en; din = i_din;
    @(posedge clk);
    #1;
    model_cycle(i_init, i_load, 32'(i_seed), i_en, i_din);
    compare_all();
  endtask

  typedef struct {
    bit         init, load, en, din;
    logic [9:0] seed;
    logic [9:0] exp_lfsr;
    bit         exp_lock, exp_pd;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int pdc;
    int pd_at;
    int guard;
    bit d;

    tbl.push_back('{0, 0, 1, 0, 10'h000, 10'h002, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 10'h000, 10'h004, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 10'h000, 10'h008, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 10'h000, 10'h010, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 10'h000, 10'h020, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 10'h000, 10'h040, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 10'h000, 10'h081, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 10'h000, 10'h102, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 10'h000, 10'h204, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 10'h000, 10'h009, 0, 0});
    tbl.push_back('{1, 1, 1, 0, 10'h3AA, 10'h001, 0, 0});
    tbl.push_back('{0, 1, 1, 0, 10'h155, 10'h155, 0, 0});
    tbl.push_back('{0, 1, 1, 0, 10'h000, 10'h001, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 10'h000, 10'h001, 0, 0});
    tbl.push_back('{0, 0, 1, 1, 10'h000, 10'h003, 0, 0});

    rst = 1'b1; init = 0; load = 0; en = 0; din = 0; seed_in = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk("reset_lfsr", lfsr_a, 1);
    chk("reset_lockup", lock_a, 0);
    chk("reset_period_done", pd_a, 0);
    chk("reset_period_len", len_a, 0);
    chk("reset_period_valid", pv_a, 0);
    compare_all();

    // Table: first enabled sequence, priority, load and lock-up on zero seed.
    for (int r = 0; r < tbl.size(); r++) begin
      cyc(tbl[r].init, tbl[r].load, tbl[r].seed, tbl[r].en, tbl[r].din);
      chk($sformatf("tbl%0d_lfsr", r), lfsr_a, tbl[r].exp_lfsr);
      chk($sformatf("tbl%0d_lockup", r), lock_a, tbl[r].exp_lock);
      chk($sformatf("tbl%0d_period_done", r), pd_a, tbl[r].exp_pd);
      if (r == 0) chk("steps2_first", lfsr_b, 10'h004);
    end

    // Full period from SEED, twice.
    cyc(1, 0, 0, 0, 0);
    for (int rep = 0; rep < 2; rep++) begin
      pdc = 0;
      pd_at = -1;
      for (int n = 1; n <= 1023; n++) begin
        cyc(0, 0, 0, 1, 0);
        if (pd_a) begin
          pdc++;
          pd_at = n;
        end
      end
      chk("period_pulse_count", pdc, 1);
      chk("period_pulse_cycle", pd_at, 1023);
      chk("period_len_1023", len_a, 1023);
      chk("period_valid_set", pv_a, 1);
      chk("period_end_lfsr", lfsr_a, 1);
      chk("steps2_period_done", pd_b, 1);
      chk("steps2_period_len", len_b, 1023);
    end

    // Period from a loaded seed, then zero-seed load.
    cyc(0, 1, 10'h155, 0, 0);
    for (int n = 1; n <= 1023; n++) cyc(0, 0, 0, 1, 0);
    chk("load_period_done", pd_a, 1);
    chk("load_period_lfsr", lfsr_a, 10'h155);
    chk("load_period_len", len_a, 1023);
    cyc(0, 1, 10'h000, 1, 0);
    chk("zero_load_lfsr", lfsr_a, 1);
    chk("zero_load_lockup", lock_a, 1);
    cyc(0, 0, 0, 1, 0);
    chk("zero_load_lockup_once", lock_a, 0);

    // Lock-up via entropy cancelling the feedback.
    cyc(0, 1, 10'h200, 0, 0);
    cyc(0, 0, 0, 1, 1);
    chk("din_to_zero", lfsr_a, 0);
    cyc(0, 0, 0, 1, 0);
    chk("lockup_lfsr", lfsr_a, 1);
    chk("lockup_pulse", lock_a, 1);
    chk("lockup_no_period", pd_a, 0);
    cyc(0, 1, 10'h001, 0, 0);
    guard = 0;
    while (m_state[0] != 0 && guard < 20) begin
      d = parity_fb(0, m_state[0]);
      cyc(0, 0, 0, 1, d);
      guard++;
    end
    chk("walk_to_zero", lfsr_a, 0);
    cyc(0, 0, 0, 1, 0);
    chk("walk_lockup_lfsr", lfsr_a, 1);
    chk("walk_lockup_pulse", lock_a, 1);
    chk("walk_lockup_no_period", pd_a, 0);

    // Asynchronous reset while period_done is high.
    cyc(1, 0, 0, 0, 0);
    for (int n = 1; n <= 1023; n++) cyc(0, 0, 0, 1, 0);
    chk("pre_rst_period_done", pd_a, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_lfsr", lfsr_a, 1);
    chk("async_rst_period_done", pd_a, 0);
    chk("async_rst_period_valid", pv_a, 0);
    chk("async_rst_period_len", len_a, 0);
    model_reset();
    compare_all();
    @(negedge clk);
    rst = 1'b0;

    // Randomised traffic on all three instances.
    for (int n = 0; n < 1500; n++) begin
      cyc($urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0,
          ($urandom_range(0, 3) == 0) ? 10'h000 : 10'($urandom),
          $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
